// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: operation encoding, FSM states
// and the default datapath width of the external ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, two synchronous write
// ports (ALU writeback and direct load); writeback wins an address collision.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = 4,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDXW-1:0]  rs1_addr_i,
    input  logic [IDXW-1:0]  rs2_addr_i,
    output logic [WIDTH-1:0] rs1_data_o,
    output logic [WIDTH-1:0] rs2_data_o,
    input  logic             wb_en_i,
    input  logic [IDXW-1:0]  wb_addr_i,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic             ld_en_i,
    input  logic [IDXW-1:0]  ld_addr_i,
    input  logic [WIDTH-1:0] ld_data_i
);

    logic [WIDTH-1:0] mem_q [NREGS];

    assign rs1_data_o = mem_q[rs1_addr_i];
    assign rs2_data_o = mem_q[rs2_addr_i];

    // Storage update; the writeback assignment comes last so it overrides a load to the same entry
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: {WIDTH{1'b0}}};
        end else begin
            if (ld_en_i) begin
                mem_q[ld_addr_i] <= ld_data_i;
            end
            if (wb_en_i) begin
                mem_q[wb_addr_i] <= wb_data_i;
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the external combinational ALU: accepts a command,
// presents registered operands for one cycle, writes back and returns the result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = 4,
    localparam int IDXW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_rd,
    input  logic [IDXW-1:0]  cmd_rs1,
    input  logic [IDXW-1:0]  cmd_rs2,
    input  logic             cmd_imm_en,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic             ld_en,
    input  logic [IDXW-1:0]  ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_neg
);

    function automatic logic calc_zero(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    function automatic logic calc_neg(input logic [WIDTH-1:0] value);
        return value[WIDTH-1];
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    alu_op_t          alu_ctrl_q, alu_ctrl_d;
    logic [IDXW-1:0]  rd_q, rd_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_neg_q, rsp_neg_d;

    logic [WIDTH-1:0] rf_rs1_data_s;
    logic [WIDTH-1:0] rf_rs2_data_s;
    logic             wb_en_s;

    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign rsp_valid   = (state_q == RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_neg     = rsp_neg_q;

    // A reset landing in EXEC must suppress the writeback of the dropped op
    assign wb_en_s = (state_q == EXEC) && !reset;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .rs1_addr_i (cmd_rs1),
        .rs2_addr_i (cmd_rs2),
        .rs1_data_o (rf_rs1_data_s),
        .rs2_data_o (rf_rs2_data_s),
        .wb_en_i    (wb_en_s),
        .wb_addr_i  (rd_q),
        .wb_data_i  (alu_result),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data)
    );

    // Next-state and register next-value logic for the issue FSM
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rd_d         = rd_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d    = EXEC;
                    alu_a_d    = rf_rs1_data_s;
                    alu_b_d    = cmd_imm_en ? cmd_imm : rf_rs2_data_s;
                    alu_ctrl_d = alu_op_t'(cmd_op);
                    rd_d       = cmd_rd;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d      = RESP;
                rsp_result_d = alu_result;
                rsp_zero_d   = calc_zero(alu_result);
                rsp_neg_d    = calc_neg(alu_result);
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            alu_a_q      <= {WIDTH{1'b0}};
            alu_b_q      <= {WIDTH{1'b0}};
            alu_ctrl_q   <= ALU_ADD;
            rd_q         <= {IDXW{1'b0}};
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rd_q         <= rd_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a vector table for single operations plus
// hand-written sequences for backpressure, load collisions and mid-op reset.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic       cmd_imm_en;
    logic [7:0] cmd_imm;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a, alu_b;
    logic [1:0] alu_control;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero, rsp_neg;

    int tests_run = 0;
    int tests_failed = 0;

    alu_issue_ctrl #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU
    always_comb begin
        case (alu_control)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            2'b11:   alu_result = alu_a | alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    typedef struct {
        logic       pre_en;
        logic [1:0] pre_addr;
        logic [7:0] pre_data;
        logic [1:0] op;
        logic [1:0] rd, rs1, rs2;
        logic       imm_en;
        logic [7:0] imm;
        logic [7:0] exp_a, exp_b, exp_res;
        logic       exp_z, exp_n;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Present a command, wait (bounded) for cmd_ready, return #1 after the accept edge
    task automatic issue(input string name, input logic [1:0] op, rd, rs1, rs2,
                         input logic imm_en, input logic [7:0] imm);
        int n;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = imm_en; cmd_imm = imm; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_accept"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, rd, rs1, rs2,
                          input logic imm_en, input logic [7:0] imm,
                          input logic [7:0] ea, eb, er, input logic ez, en);
        rsp_ready = 1'b1;
        issue(name, op, rd, rs1, rs2, imm_en, imm);
        @(negedge clk);
        check({name, "_exec_rsp_valid"}, rsp_valid, 0);
        check({name, "_alu_a"}, alu_a, ea);
        check({name, "_alu_b"}, alu_b, eb);
        check({name, "_alu_control"}, alu_control, op);
        @(negedge clk);
        check({name, "_rsp_valid"}, rsp_valid, 1);
        check({name, "_result"}, rsp_result, er);
        check({name, "_zero"}, rsp_zero, ez);
        check({name, "_neg"}, rsp_neg, en);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pre   addr  data    op     rd    rs1   rs2   imm  imm     a       b       res     z     n
        vecs[0] = '{1'b0, 2'd0, 8'h00, 2'b00, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'd100, 8'd27,  8'd127, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 8'h00, 2'b11, 2'd2, 2'd2, 2'd0, 1'b1, 8'h00, 8'h7F,  8'h00,  8'h7F,  1'b0, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 8'h80, 2'b01, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 8'h05, 2'b01, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00, 8'h05,  8'h05,  8'h00,  1'b1, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 8'hF0, 2'b10, 2'd2, 2'd0, 2'd0, 1'b1, 8'h3C, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 8'h3C, 2'b11, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'hF0,  8'h3C,  8'hFC,  1'b0, 1'b1};
        vecs[6] = '{1'b0, 2'd0, 8'h00, 2'b00, 2'd0, 2'd3, 2'd3, 1'b0, 8'h00, 8'hFC,  8'hFC,  8'hF8,  1'b0, 1'b1};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 2'b01, 2'd1, 2'd1, 2'd0, 1'b1, 8'h3D, 8'h3C,  8'h3D,  8'hFF,  1'b0, 1'b1};
        vecs[8] = '{1'b0, 2'd0, 8'h00, 2'b11, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 8'hF8,  8'h00,  8'hF8,  1'b0, 1'b1};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = 2'd0; cmd_rs1 = 2'd0;
        cmd_rs2 = 2'd0; cmd_imm_en = 1'b0; cmd_imm = 8'h00; ld_en = 1'b0; ld_addr = 2'd0;
        ld_data = 8'h00; rsp_ready = 1'b1;

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_rsp_neg", rsp_neg, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        load(2'd0, 8'd100);
        load(2'd1, 8'd27);

        // Table-driven single operations
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pre_en) load(vecs[i].pre_addr, vecs[i].pre_data);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].imm_en, vecs[i].imm, vecs[i].exp_a, vecs[i].exp_b,
                   vecs[i].exp_res, vecs[i].exp_z, vecs[i].exp_n);
        end

        // Backpressure: r1 = r3(0xFC) + 5 = 0x01, second command held meanwhile
        rsp_ready = 1'b0;
        issue("bp1", 2'b00, 2'd1, 2'd3, 2'd0, 1'b1, 8'h05);
        cmd_op = 2'b00; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_imm_en = 1'b1; cmd_imm = 8'h10;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("bp_exec_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_rsp_valid", rsp_valid, 1);
            check("bp_hold_result", rsp_result, 8'h01);
            check("bp_hold_zero", rsp_zero, 0);
            check("bp_hold_cmd_ready", cmd_ready, 0);
            check("bp_hold_alu_a", alu_a, 8'hFC);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_after_fire_cmd_ready", cmd_ready, 1);
        check("bp_after_fire_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp2_alu_a_dependent", alu_a, 8'h01);
        check("bp2_alu_b", alu_b, 8'h10);
        @(negedge clk);
        check("bp2_result", rsp_result, 8'h11);
        @(posedge clk); #1;

        // Load to rd on the writeback edge: writeback must win (r0 = r2 + 1 = 0x12)
        issue("wbcol", 2'b00, 2'd0, 2'd2, 2'd0, 1'b1, 8'h01);
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h55;
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk);
        check("wbcol_result", rsp_result, 8'h12);
        @(posedge clk); #1;
        run_op("wbcol_read_r0", 2'b11, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h12, 8'h00, 8'h12, 1'b0, 1'b0);

        // Load to rs1 on the accept edge: operand uses old r1 (0x01), rf holds 0x40 afterwards
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h40;
        issue("accol", 2'b11, 2'd3, 2'd1, 2'd0, 1'b1, 8'h00);
        ld_en = 1'b0;
        @(negedge clk);
        check("accol_alu_a_old", alu_a, 8'h01);
        @(negedge clk);
        check("accol_result", rsp_result, 8'h01);
        @(posedge clk); #1;
        run_op("accol_read_r1", 2'b11, 2'd1, 2'd1, 2'd0, 1'b1, 8'h00, 8'h40, 8'h00, 8'h40, 1'b0, 1'b0);

        // Reset during EXEC, with a load pending in the same cycle
        issue("rstx", 2'b00, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01);
        reset = 1'b1; ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h77;
        @(negedge clk);
        check("rstx_cmd_ready_in_reset", cmd_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0; ld_en = 1'b0;
        @(negedge clk);
        check("rstx_rsp_valid", rsp_valid, 0);
        check("rstx_rsp_result", rsp_result, 0);
        check("rstx_alu_a", alu_a, 0);
        check("rstx_alu_b", alu_b, 0);
        check("rstx_alu_control", alu_control, 0);
        check("rstx_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        run_op("rstx_read_r2", 2'b11, 2'd2, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op("rstx_read_r0", 2'b11, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        // Reset during RESP
        load(2'd1, 8'h22);
        rsp_ready = 1'b0;
        issue("rstr", 2'b00, 2'd3, 2'd1, 2'd0, 1'b1, 8'h11);
        @(negedge clk);
        @(negedge clk);
        check("rstr_pre_rsp_valid", rsp_valid, 1);
        check("rstr_pre_result", rsp_result, 8'h33);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rstr_rsp_valid", rsp_valid, 0);
        check("rstr_rsp_result", rsp_result, 0);
        check("rstr_rsp_zero", rsp_zero, 0);
        check("rstr_rsp_neg", rsp_neg, 0);
        check("rstr_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        run_op("rstr_read_r3", 2'b11, 2'd3, 2'd3, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op("rstr_read_r1", 2'b11, 2'd1, 2'd1, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
